// File: rtl/tri_port_memory_controller.sv
// Fixed-priority (CPU > Acl > DMA) arbiter in front of a single-port word RAM.
// One access per cycle; the granted master receives registered data and a one-cycle valid.
module tri_port_memory_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CPUEn,
    input  logic                  CPUWrEn,
    input  logic [ADDR_WIDTH-1:0] CPUAddr,
    input  logic [DATA_WIDTH-1:0] CPUData,
    input  logic                  AclEn,
    input  logic                  AclWrEn,
    input  logic [ADDR_WIDTH-1:0] AclAddr,
    input  logic [DATA_WIDTH-1:0] AclData,
    input  logic                  DMAEn,
    input  logic                  DMAWrEn,
    input  logic [ADDR_WIDTH-1:0] DMAAddr,
    input  logic [DATA_WIDTH-1:0] DMAData,
    output logic [DATA_WIDTH-1:0] CPUOut,
    output logic                  CPUValid,
    output logic [DATA_WIDTH-1:0] AclOut,
    output logic                  AclValid,
    output logic [DATA_WIDTH-1:0] DMAOut,
    output logic                  DMAValid
);
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_ACL, GNT_DMA} grant_e;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    grant_e                grant;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] resp;

    logic [DATA_WIDTH-1:0] cpu_out_d, cpu_out_q;
    logic [DATA_WIDTH-1:0] acl_out_d, acl_out_q;
    logic [DATA_WIDTH-1:0] dma_out_d, dma_out_q;
    logic                  cpu_valid_d, cpu_valid_q;
    logic                  acl_valid_d, acl_valid_q;
    logic                  dma_valid_d, dma_valid_q;

    always_comb begin
        grant    = GNT_NONE;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        if (CPUEn) begin
            grant    = GNT_CPU;
            sel_wr   = CPUWrEn;
            sel_addr = CPUAddr;
            sel_data = CPUData;
        end else if (AclEn) begin
            grant    = GNT_ACL;
            sel_wr   = AclWrEn;
            sel_addr = AclAddr;
            sel_data = AclData;
        end else if (DMAEn) begin
            grant    = GNT_DMA;
            sel_wr   = DMAWrEn;
            sel_addr = DMAAddr;
            sel_data = DMAData;
        end
    end

    // Writes echo their own data; reads see the array contents from before this edge.
    assign resp = sel_wr ? sel_data : mem[sel_addr];

    always_comb begin
        cpu_out_d   = cpu_out_q;
        acl_out_d   = acl_out_q;
        dma_out_d   = dma_out_q;
        cpu_valid_d = 1'b0;
        acl_valid_d = 1'b0;
        dma_valid_d = 1'b0;
        case (grant)
            GNT_CPU: begin cpu_out_d = resp; cpu_valid_d = 1'b1; end
            GNT_ACL: begin acl_out_d = resp; acl_valid_d = 1'b1; end
            GNT_DMA: begin dma_out_d = resp; dma_valid_d = 1'b1; end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_out_q   <= '0;
            acl_out_q   <= '0;
            dma_out_q   <= '0;
            cpu_valid_q <= 1'b0;
            acl_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
        end else begin
            cpu_out_q   <= cpu_out_d;
            acl_out_q   <= acl_out_d;
            dma_out_q   <= dma_out_d;
            cpu_valid_q <= cpu_valid_d;
            acl_valid_q <= acl_valid_d;
            dma_valid_q <= dma_valid_d;
        end
    end

    // NOTE: the RAM array is deliberately not reset; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && sel_wr) begin
            mem[sel_addr] <= sel_data;
        end
    end

    assign CPUOut   = cpu_out_q;
    assign AclOut   = acl_out_q;
    assign DMAOut   = dma_out_q;
    assign CPUValid = cpu_valid_q;
    assign AclValid = acl_valid_q;
    assign DMAValid = dma_valid_q;
endmodule

// File: tb/tb_tri_port_memory_controller.sv
// Scoreboard bench for tri_port_memory_controller: each driven cycle pushes the expected
// valid pattern and per-master output, popped and compared one edge later.
module tb_tri_port_memory_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en;      // bit 0 CPU, 1 Acl, 2 DMA
    logic [2:0]  wr;
    logic [15:0] addr [3];
    logic [31:0] data [3];
    logic [31:0] cpu_out, acl_out, dma_out;
    logic        cpu_valid, acl_valid, dma_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  vmask;
        logic [31:0] outv [3];
        logic [2:0]  known;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem_m [int];
    logic [31:0] last_out [3];
    logic [2:0]  last_known;

    tri_port_memory_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .CPUEn   (en[0]),
        .CPUWrEn (wr[0]),
        .CPUAddr (addr[0]),
        .CPUData (data[0]),
        .AclEn   (en[1]),
        .AclWrEn (wr[1]),
        .AclAddr (addr[1]),
        .AclData (data[1]),
        .DMAEn   (en[2]),
        .DMAWrEn (wr[2]),
        .DMAAddr (addr[2]),
        .DMAData (data[2]),
        .CPUOut  (cpu_out),
        .CPUValid(cpu_valid),
        .AclOut  (acl_out),
        .AclValid(acl_valid),
        .DMAOut  (dma_out),
        .DMAValid(dma_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Predict the effect of the current inputs, push it, then advance one edge and compare.
    task automatic tick(input string tag);
        exp_t e;
        int   who;
        logic [31:0] dout [3];
        who = -1;
        e.vmask = 3'b000;
        if (rst) begin
            for (int m = 0; m < 3; m++) begin
                last_out[m] = 32'h0;
            end
            last_known = 3'b111;
        end else begin
            if (en[0])      who = 0;
            else if (en[1]) who = 1;
            else if (en[2]) who = 2;
            if (who >= 0) begin
                e.vmask[who] = 1'b1;
                if (wr[who]) begin
                    mem_m[int'(addr[who])] = data[who];
                    last_out[who]   = data[who];
                    last_known[who] = 1'b1;
                end else if (mem_m.exists(int'(addr[who]))) begin
                    last_out[who]   = mem_m[int'(addr[who])];
                    last_known[who] = 1'b1;
                end else begin
                    last_known[who] = 1'b0;
                end
            end
        end
        e.outv  = last_out;
        e.known = last_known;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        dout[0] = cpu_out;
        dout[1] = acl_out;
        dout[2] = dma_out;
        check({tag, ":valid"}, {29'h0, dma_valid, acl_valid, cpu_valid}, {29'h0, e.vmask});
        for (int m = 0; m < 3; m++) begin
            if (e.known[m]) check($sformatf("%s:out%0d", tag, m), dout[m], e.outv[m]);
        end
    endtask

    task automatic idle_inputs();
        en = 3'b000;
        wr = 3'b000;
        for (int m = 0; m < 3; m++) begin
            addr[m] = 16'h0;
            data[m] = 32'h0;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          m;
        idle_inputs();
        last_known = 3'b111;
        for (int k = 0; k < 3; k++) last_out[k] = 32'h0;

        // Reset with a pending CPU write that must not land.
        rst     = 1'b1;
        en[0]   = 1'b1;
        wr[0]   = 1'b1;
        addr[0] = 16'h0010;
        data[0] = 32'hDEADBEEF;
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        idle_inputs();
        tick("post_reset_idle");
        en[0]   = 1'b1;
        addr[0] = 16'h0010;
        tick("reset_read");
        check("reset_no_write", {31'h0, cpu_out != 32'hDEADBEEF}, 32'h1);

        // Single-master write echo.
        for (int i = 0; i < 100; i++) begin
            idle_inputs();
            m       = int'($urandom_range(0, 2));
            v       = $urandom;
            en[m]   = 1'b1;
            wr[m]   = 1'b1;
            addr[m] = v[15:0];
            data[m] = v;
            tick("echo");
        end

        // DMA write, Acl read back.
        idle_inputs();
        en[2] = 1'b1; wr[2] = 1'b1; addr[2] = 16'hABCD; data[2] = 32'h12345678;
        tick("dma_wr");
        idle_inputs();
        en[1] = 1'b1; addr[1] = 16'hABCD;
        tick("acl_rd");
        check("acl_rd_data", acl_out, 32'h12345678);

        // Three-way contention on one address; each master drops En after its Valid.
        en   = 3'b111;
        wr   = 3'b111;
        for (int k = 0; k < 3; k++) addr[k] = 16'h0001;
        data[0] = 32'h11111111; data[1] = 32'h22222222; data[2] = 32'h33333333;
        tick("arb_cpu");
        en[0] = 1'b0;
        tick("arb_acl");
        en[1] = 1'b0;
        tick("arb_dma");
        idle_inputs();
        en[0] = 1'b1; addr[0] = 16'h0001;
        tick("arb_final_rd");
        check("arb_final_data", cpu_out, 32'h33333333);

        // CPUOut must hold across other masters' traffic.
        idle_inputs();
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0200; data[0] = 32'h0000AAAA;
        tick("hold_set");
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            m       = (i % 2 == 0) ? 1 : 2;
            v       = $urandom;
            en[m]   = 1'b1;
            wr[m]   = v[0];
            addr[m] = {8'h03, v[7:0]};
            data[m] = v;
            tick("hold_traffic");
            check("hold_cpu_out", cpu_out, 32'h0000AAAA);
            check("hold_cpu_valid", {31'h0, cpu_valid}, 32'h0);
        end

        // Back-to-back write then read from CPU.
        idle_inputs();
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0005; data[0] = 32'hC0FFEE05;
        tick("b2b_wr");
        check("b2b_wr_valid", {31'h0, cpu_valid}, 32'h1);
        wr[0] = 1'b0; data[0] = 32'h0;
        tick("b2b_rd");
        check("b2b_rd_valid", {31'h0, cpu_valid}, 32'h1);
        check("b2b_rd_data", cpu_out, 32'hC0FFEE05);

        idle_inputs();
        tick("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
